// File: rtl/hough_pkg.sv
// Shared definitions for the Hough front end: default frame size, the reader
// state encoding and width helpers for addresses and raster coordinates.
package hough_pkg;
  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  // Bits needed to index n distinct values (never narrower than one bit).
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int count_bits(input int n);
    return bits_for(n + 1);
  endfunction
endpackage

// File: rtl/hysteresis_edge_reader.sv
// Raster-scans the hysteresis edge map in BRAM and pushes the (x, y) of every
// non-zero pixel into the Hough FIFO, back-pressured by out_full.
module hysteresis_edge_reader
  import hough_pkg::*;
#(
  parameter int WIDTH              = DEF_WIDTH,
  parameter int HEIGHT             = DEF_HEIGHT,
  parameter int REDUCED_IMAGE_SIZE = WIDTH * HEIGHT,
  localparam int AW = bits_for(REDUCED_IMAGE_SIZE),
  localparam int XW = bits_for(WIDTH),
  localparam int YW = bits_for(HEIGHT),
  localparam int CW = count_bits(REDUCED_IMAGE_SIZE)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          hough_start,
  output logic [AW-1:0] bram_rd_addr,
  input  logic [7:0]    bram_rd_data,
  input  logic          out_full,
  output logic          out_wr_en,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] edge_count,
  output logic          hysteresis_read_done
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(REDUCED_IMAGE_SIZE - 1);
  localparam logic [XW-1:0] COL_LAST  = XW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [AW-1:0] addr;

  logic          s1_valid;
  logic [XW-1:0] s1_col;
  logic [YW-1:0] s1_row;
  logic [AW-1:0] s1_addr;

  logic is_edge, stall;

  always_comb begin
    is_edge   = s1_valid && (bram_rd_data != 8'h00);
    stall     = is_edge && out_full;
    out_wr_en = is_edge && !out_full;
    out_x     = out_wr_en ? s1_col : '0;
    out_y     = out_wr_en ? s1_row : '0;
    // On a stall the pending pixel is re-read so its data is valid again next cycle.
    bram_rd_addr         = stall ? s1_addr : addr;
    hysteresis_read_done = (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hough_start) state_nxt = SCAN;
      SCAN:    if (!stall && addr == ADDR_LAST) state_nxt = DRAIN;
      DRAIN:   if (!stall) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      s1_valid   <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      s1_addr    <= '0;
      edge_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          col      <= '0;
          row      <= '0;
          addr     <= '0;
          s1_valid <= 1'b0;
          // Count survives DONE->IDLE and is only cleared when a new frame starts.
          if (hough_start) edge_count <= '0;
        end
        SCAN: begin
          if (!stall) begin
            s1_valid <= 1'b1;
            s1_col   <= col;
            s1_row   <= row;
            s1_addr  <= addr;
            // Counters park on the last pixel so DRAIN still presents a valid address.
            if (addr != ADDR_LAST) begin
              addr <= addr + AW'(1);
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + YW'(1);
              end else begin
                col <= col + XW'(1);
              end
            end
          end
        end
        DRAIN:   if (!stall) s1_valid <= 1'b0;
        default: ;
      endcase
      if (out_wr_en) edge_count <= edge_count + CW'(1);
    end
  end

endmodule
